// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the sram_ctrl block.
`timescale 1ns/1ps
package sram_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 4;

  // Controller phases: zero-fill after reset, then normal traffic.
  typedef enum logic {
    INIT,
    RUN
  } state_t;

  // One client request at the default widths.
  typedef struct packed {
    logic                      we;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] wdata;
  } req_t;

  // Number of SRAM words for a given address width.
  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/sram_ctrl_rsp.sv
// Per-channel read-response pipeline: remembers that a read was accepted,
// then captures the SRAM output one cycle later and strobes rsp_valid.
`timescale 1ns/1ps
module sram_ctrl_rsp #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_fire,
  input  logic [DATA_WIDTH-1:0] q,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata
);

  logic pending;

  // Track the accepted read, then present the SRAM word; data holds when idle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      pending   <= rd_fire;
      rsp_valid <= pending;
      if (pending) rsp_rdata <= q;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Two-channel controller in front of a true dual-port SRAM. Zero-fills the
// memory after reset, then arbitrates same-address hazards with A priority.
`timescale 1ns/1ps
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_a,
  output logic                  req_ready_a,
  input  logic                  req_we_a,
  input  logic [ADDR_WIDTH-1:0] req_addr_a,
  input  logic [DATA_WIDTH-1:0] req_wdata_a,
  output logic                  rsp_valid_a,
  output logic [DATA_WIDTH-1:0] rsp_rdata_a,
  input  logic                  req_valid_b,
  output logic                  req_ready_b,
  input  logic                  req_we_b,
  input  logic [ADDR_WIDTH-1:0] req_addr_b,
  input  logic [DATA_WIDTH-1:0] req_wdata_b,
  output logic                  rsp_valid_b,
  output logic [DATA_WIDTH-1:0] rsp_rdata_b,
  output logic                  init_done,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic                  we_a,
  input  logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  we_b,
  input  logic [DATA_WIDTH-1:0] q_b
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam int HALF  = DEPTH / 2;
  // Each port clears half the array, so the counter spans DEPTH/2 words.
  localparam int CW    = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          run;
  logic          conflict;
  logic          fire_a;
  logic          fire_b;

  // Zero-fill sequencer: walk the lower half on A and upper half on B, then run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        state     <= RUN;
        init_done <= 1'b1;
      end
    end
  end

  assign run = (state == RUN);

  // B yields to A whenever both touch the same word and either one writes;
  // two reads of one word can proceed together.
  assign conflict = req_valid_a & req_valid_b & (req_addr_a == req_addr_b)
                  & (req_we_a | req_we_b);

  assign req_ready_a = run;
  assign req_ready_b = run & ~conflict;
  assign fire_a      = req_valid_a & req_ready_a;
  assign fire_b      = req_valid_b & req_ready_b;

  // SRAM port steering: fill pattern during INIT, client requests during RUN.
  // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    addr_a = req_addr_a;
    data_a = req_wdata_a;
    we_a   = req_we_a & fire_a;
    addr_b = req_addr_b;
    data_b = req_wdata_b;
    we_b   = req_we_b & fire_b;
    if (!run) begin
      addr_a = ADDR_WIDTH'(cnt);
      addr_b = ADDR_WIDTH'(cnt) + ADDR_WIDTH'(HALF);
      data_a = '0;
      data_b = '0;
      // Held off while rst is asserted so the SRAM sees no writes during reset.
      we_a   = ~rst;
      we_b   = ~rst;
    end
  end

  sram_ctrl_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_a (
    .clk       (clk),
    .rst       (rst),
    .rd_fire   (fire_a & ~req_we_a),
    .q         (q_a),
    .rsp_valid (rsp_valid_a),
    .rsp_rdata (rsp_rdata_a)
  );

  sram_ctrl_rsp #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_b (
    .clk       (clk),
    .rst       (rst),
    .rd_fire   (fire_b & ~req_we_b),
    .q         (q_b),
    .rsp_valid (rsp_valid_b),
    .rsp_rdata (rsp_rdata_b)
  );

endmodule
